// File: rtl/gt_block_lock_pkg.sv
// Shared types and helpers for the 64B/66B receive block-lock controller.
package gt_block_lock_pkg;

   typedef enum logic [2:0] {
      HUNT,
      SLIP,
      WAIT,
      LOCK,
      RSTREQ
   } state_t;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   // Only the two legal 64B/66B sync headers count as valid.
   function automatic logic is_valid_sh(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage

// File: rtl/gt_rx_block_lock.sv
// 64B/66B RX block-lock controller: slips the gearbox until headers align, reports lock,
// and requests a GT RX reset when alignment is never found. GT_BLOCK_LOCK_STATS_EN adds lock-loss/slip counters.
module gt_rx_block_lock
   import gt_block_lock_pkg::*;
#(
   parameter int SH_WINDOW    = 64,
   parameter int SH_INVLD_MAX = 16,
   parameter int SLIP_WAIT    = 32,
   parameter int MAX_SLIPS    = 66
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_done,
   input  logic [1:0] i_rx_header,
   input  logic       i_rx_header_valid,
   output logic       o_rx_slipbit,
   output logic       o_block_lock,
   output logic       o_rx_rst_req
`ifdef GT_BLOCK_LOCK_STATS_EN
   ,
   output logic [15:0] o_lock_loss_cnt,
   output logic [15:0] o_slip_total
`endif
);

   localparam int SH_W   = $clog2(SH_WINDOW + 1);
   localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
   localparam int SLIP_W = $clog2(MAX_SLIPS + 1);

   localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_WINDOW - 1);
   localparam logic [SH_W-1:0]   SH_ONE    = SH_W'(1);
   localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX - 1);
   localparam logic [INV_W-1:0]  INV_ONE   = INV_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(MAX_SLIPS);
   localparam logic [SLIP_W-1:0] SLIP_ONE  = SLIP_W'(1);

   state_t              state;
   state_t              state_next;
   logic [SH_W-1:0]     sh_cnt;
   logic [SH_W-1:0]     sh_next;
   logic [INV_W-1:0]    invld_cnt;
   logic [INV_W-1:0]    invld_next;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [WAIT_W-1:0]   wait_next;
   logic [SLIP_W-1:0]   slip_cnt;
   logic [SLIP_W-1:0]   slip_next;
   logic                hdr_ok;

   always_comb begin
      state_next = state;
      sh_next    = sh_cnt;
      invld_next = invld_cnt;
      wait_next  = wait_cnt;
      slip_next  = slip_cnt;
      hdr_ok     = is_valid_sh(i_rx_header);

      if (!i_rx_done) begin
         state_next = HUNT;
         sh_next    = '0;
         invld_next = '0;
         wait_next  = '0;
         slip_next  = '0;
      end else begin
         unique case (state)
            HUNT: begin
               if (i_rx_header_valid) begin
                  if (hdr_ok) begin
                     if (sh_cnt == SH_LAST) begin
                        state_next = LOCK;
                        sh_next    = '0;
                        invld_next = '0;
                        slip_next  = '0;
                     end else begin
                        sh_next = sh_cnt + SH_ONE;
                     end
                  end else if (slip_cnt < SLIP_MAX) begin
                     state_next = SLIP;
                     slip_next  = slip_cnt + SLIP_ONE;
                     sh_next    = '0;
                  end else begin
                     state_next = RSTREQ;
                  end
               end
            end
            SLIP: begin
               state_next = WAIT;
               wait_next  = '0;
            end
            // Gearbox output is unreliable right after a slip, so headers are ignored here.
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state_next = HUNT;
                  wait_next  = '0;
               end else begin
                  wait_next = wait_cnt + WAIT_ONE;
               end
            end
            LOCK: begin
               if (i_rx_header_valid) begin
                  if (!hdr_ok && (invld_cnt == INV_LAST)) begin
                     state_next = SLIP;
                     slip_next  = SLIP_ONE;
                     sh_next    = '0;
                     invld_next = '0;
                  end else if (sh_cnt == SH_LAST) begin
                     sh_next    = '0;
                     invld_next = '0;
                  end else begin
                     sh_next = sh_cnt + SH_ONE;
                     if (!hdr_ok) begin
                        invld_next = invld_cnt + INV_ONE;
                     end
                  end
               end
            end
            RSTREQ: begin
               state_next = HUNT;
               sh_next    = '0;
               invld_next = '0;
               wait_next  = '0;
               slip_next  = '0;
            end
            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= HUNT;
         sh_cnt       <= '0;
         invld_cnt    <= '0;
         wait_cnt     <= '0;
         slip_cnt     <= '0;
         o_rx_slipbit <= 1'b0;
         o_block_lock <= 1'b0;
         o_rx_rst_req <= 1'b0;
      end else begin
         state        <= state_next;
         sh_cnt       <= sh_next;
         invld_cnt    <= invld_next;
         wait_cnt     <= wait_next;
         slip_cnt     <= slip_next;
         o_rx_slipbit <= (state_next == SLIP);
         o_block_lock <= (state_next == LOCK);
         o_rx_rst_req <= (state_next == RSTREQ);
      end
   end

`ifdef GT_BLOCK_LOCK_STATS_EN
   // Saturating diagnostics; only i_rst clears them so they survive GT resets.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_lock_loss_cnt <= '0;
         o_slip_total    <= '0;
      end else begin
         if ((state == LOCK) && (state_next == SLIP) && (o_lock_loss_cnt != 16'hFFFF)) begin
            o_lock_loss_cnt <= o_lock_loss_cnt + 16'd1;
         end
         if ((state != SLIP) && (state_next == SLIP) && (o_slip_total != 16'hFFFF)) begin
            o_slip_total <= o_slip_total + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_gt_rx_block_lock.sv
// Self-checking bench for gt_rx_block_lock: directed scenarios plus random traffic against a behavioural model.
module tb_gt_rx_block_lock;

   localparam int WINDOW   = 64;
   localparam int BAD_MAX  = 16;
   localparam int SETTLE   = 32;
   localparam int SLIP_LIM = 66;

   logic       clk;
   logic       rst;
   logic       rx_done;
   logic [1:0] rx_header;
   logic       rx_header_valid;
   logic       o_rx_slipbit;
   logic       o_block_lock;
   logic       o_rx_rst_req;
`ifdef GT_BLOCK_LOCK_STATS_EN
   logic [15:0] o_lock_loss_cnt;
   logic [15:0] o_slip_total;
`endif

   gt_rx_block_lock dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_rx_done         (rx_done),
      .i_rx_header       (rx_header),
      .i_rx_header_valid (rx_header_valid),
      .o_rx_slipbit      (o_rx_slipbit),
      .o_block_lock      (o_block_lock),
      .o_rx_rst_req      (o_rx_rst_req)
`ifdef GT_BLOCK_LOCK_STATS_EN
      ,
      .o_lock_loss_cnt   (o_lock_loss_cnt),
      .o_slip_total      (o_slip_total)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // Behavioural view: locked flag, a blackout length after each slip, and plain header tallies.
   bit m_locked;
   int m_blackout;
   int m_run;
   int m_win;
   int m_bad;
   int m_slips;
   int m_loss;
   int m_slip_total;
   bit exp_slip;
   bit exp_lock;
   bit exp_rst;

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear_link();
      m_locked   = 1'b0;
      m_blackout = 0;
      m_run      = 0;
      m_win      = 0;
      m_bad      = 0;
      m_slips    = 0;
   endtask

   task automatic model_slip();
      exp_slip   = 1'b1;
      m_blackout = 1 + SETTLE;
      if (m_slip_total < 65535) m_slip_total++;
   endtask

   task automatic model_step();
      bit good;
      bit was_rstreq;
      good       = (rx_header == 2'b01) || (rx_header == 2'b10);
      was_rstreq = exp_rst;
      exp_slip   = 1'b0;
      exp_rst    = 1'b0;
      if (rst) begin
         model_clear_link();
         m_loss       = 0;
         m_slip_total = 0;
      end else if (!rx_done || was_rstreq) begin
         model_clear_link();
      end else if (m_blackout > 0) begin
         m_blackout--;
      end else if (m_locked) begin
         if (rx_header_valid) begin
            m_win++;
            if (!good) m_bad++;
            if (m_bad == BAD_MAX) begin
               m_locked = 1'b0;
               m_slips  = 1;
               m_win    = 0;
               m_bad    = 0;
               if (m_loss < 65535) m_loss++;
               model_slip();
            end else if (m_win == WINDOW) begin
               m_win = 0;
               m_bad = 0;
            end
         end
      end else if (rx_header_valid) begin
         if (good) begin
            m_run++;
            if (m_run == WINDOW) begin
               m_locked = 1'b1;
               m_run    = 0;
               m_slips  = 0;
            end
         end else if (m_slips < SLIP_LIM) begin
            m_slips++;
            m_run = 0;
            model_slip();
         end else begin
            m_run   = 0;
            exp_rst = 1'b1;
         end
      end
      exp_lock = m_locked;
   endtask

   // One clock of stimulus; returns #1 after the edge so DUT outputs reflect these inputs.
   task automatic apply_stimulus(input bit r, input bit done, input bit hv, input logic [1:0] hdr);
      @(negedge clk);
      #1;
      rst             = r;
      rx_done         = done;
      rx_header_valid = hv;
      rx_header       = hdr;
      model_step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         check_output("slipbit", {15'd0, o_rx_slipbit}, {15'd0, exp_slip});
         check_output("block_lock", {15'd0, o_block_lock}, {15'd0, exp_lock});
         check_output("rx_rst_req", {15'd0, o_rx_rst_req}, {15'd0, exp_rst});
`ifdef GT_BLOCK_LOCK_STATS_EN
         check_output("lock_loss_cnt", o_lock_loss_cnt, 16'(m_loss));
         check_output("slip_total", o_slip_total, 16'(m_slip_total));
`endif
      end
   end

   function automatic logic [1:0] rand_hdr(input int pct_good);
      if (int'($urandom_range(99)) < pct_good) return 2'($urandom_range(1, 2));
      return ($urandom_range(1) == 1) ? 2'b11 : 2'b00;
   endfunction

   task automatic do_reset();
      repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 2'b00);
      apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00);
   endtask

   task automatic good_headers(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 2'($urandom_range(1, 2)));
   endtask

   // Feeds a locked window of 64 headers with nbad invalid ones at random slots; stops on lock loss.
   task automatic window_with_bad(input int nbad);
      bit bad_pos [WINDOW];
      int placed;
      int p;
      foreach (bad_pos[i]) bad_pos[i] = 1'b0;
      placed = 0;
      while (placed < nbad) begin
         p = int'($urandom_range(WINDOW - 1));
         if (!bad_pos[p]) begin
            bad_pos[p] = 1'b1;
            placed++;
         end
      end
      for (int i = 0; i < WINDOW; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, bad_pos[i] ? 2'b11 : 2'b01);
         if (!o_block_lock) break;
      end
   endtask

   initial begin
      int slips_seen;
      bit rst_seen;
      bit slip_any;

      rst = 1'b1;
      rx_done = 1'b0;
      rx_header = 2'b00;
      rx_header_valid = 1'b0;
      exp_rst = 1'b0;
      m_loss = 0;
      m_slip_total = 0;
      model_clear_link();

      do_reset();
      check_en = 1'b1;
      check_output("reset_lock", {15'd0, o_block_lock}, 16'd0);
      check_output("reset_slip", {15'd0, o_rx_slipbit}, 16'd0);
      check_output("reset_rstreq", {15'd0, o_rx_rst_req}, 16'd0);

      // Aligned stream: lock exactly after the 64th header, no slips.
      slip_any = 1'b0;
      for (int i = 0; i < WINDOW; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, 2'b01);
         slip_any |= o_rx_slipbit;
         if (i == WINDOW - 2) check_output("aligned_lock_63", {15'd0, o_block_lock}, 16'd0);
      end
      check_output("aligned_lock_64", {15'd0, o_block_lock}, 16'd1);
      check_output("aligned_no_slip", {15'd0, slip_any}, 16'd0);

      // Misaligned by three: each bad header yields one slip pulse, then a blackout.
      do_reset();
      for (int s = 0; s < 3; s++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00);
         check_output("misalign_slip_pulse", {15'd0, o_rx_slipbit}, 16'd1);
         apply_stimulus(1'b0, 1'b1, 1'b1, rand_hdr(30));
         check_output("misalign_slip_end", {15'd0, o_rx_slipbit}, 16'd0);
         for (int i = 0; i < SETTLE; i++) apply_stimulus(1'b0, 1'b1, 1'b1, rand_hdr(30));
      end
      good_headers(WINDOW);
      check_output("misalign_lock", {15'd0, o_block_lock}, 16'd1);

      // Lock loss: two windows of 15 bad hold lock, then 16 bad drops it.
      window_with_bad(BAD_MAX - 1);
      check_output("loss15_hold_a", {15'd0, o_block_lock}, 16'd1);
      window_with_bad(BAD_MAX - 1);
      check_output("loss15_hold_b", {15'd0, o_block_lock}, 16'd1);
      window_with_bad(BAD_MAX);
      check_output("loss16_drop", {15'd0, o_block_lock}, 16'd0);
      check_output("loss16_slip", {15'd0, o_rx_slipbit}, 16'd1);

      // Never aligns: 66 slips then a single reset request.
      do_reset();
      slips_seen = 0;
      rst_seen = 1'b0;
      for (int i = 0; i < 5000 && !rst_seen; i++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00);
         if (o_rx_slipbit) slips_seen++;
         if (o_rx_rst_req) rst_seen = 1'b1;
      end
      check_output("never_rst_seen", {15'd0, rst_seen}, 16'd1);
      check_output("never_slip_count", 16'(slips_seen), 16'(SLIP_LIM));
      apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00);
      check_output("never_rst_pulse_end", {15'd0, o_rx_rst_req}, 16'd0);

      // rx_done dropped mid-blackout, then reacquire; then i_rst while locked.
      do_reset();
      apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 2'b01);
      apply_stimulus(1'b0, 1'b0, 1'b1, 2'b01);
      check_output("done_low_slip", {15'd0, o_rx_slipbit}, 16'd0);
      check_output("done_low_lock", {15'd0, o_block_lock}, 16'd0);
      check_output("done_low_rstreq", {15'd0, o_rx_rst_req}, 16'd0);
      good_headers(WINDOW);
      check_output("done_relock", {15'd0, o_block_lock}, 16'd1);
      apply_stimulus(1'b1, 1'b1, 1'b1, 2'b01);
      check_output("rst_in_lock", {15'd0, o_block_lock}, 16'd0);
      apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00);

`ifdef GT_BLOCK_LOCK_STATS_EN
      // Two lock losses and five slips in total.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         good_headers(WINDOW);
         window_with_bad(BAD_MAX);
         good_headers(1 + SETTLE);
      end
      for (int k = 0; k < 3; k++) begin
         apply_stimulus(1'b0, 1'b1, 1'b1, 2'b00);
         good_headers(1 + SETTLE);
      end
      check_output("stats_loss", o_lock_loss_cnt, 16'd2);
      check_output("stats_slips", o_slip_total, 16'd5);
`endif

      // Random traffic with occasional link drops and resets.
      for (int i = 0; i < 4000; i++) begin
         int pct;
         pct = (i % 1000 < 500) ? 97 : 60;
         apply_stimulus(($urandom_range(499) == 0), ($urandom_range(99) != 0),
                        ($urandom_range(3) != 0), rand_hdr(pct));
      end

      @(negedge clk);
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
